// File: rtl/gate_truth_checker_pkg.sv
// Shared constants for the gate truth-table checker: FSM encoding and truth tables.
// No latency: constants and types only.
// No flow control: constants and types only.
// Truth tables are indexed by {A,B}; bit i is the expected Y for vector i.
package gate_truth_checker_pkg;

  localparam int VEC_COUNT = 4;

  // Expected-output tables, bit index = {A,B}
  localparam logic [3:0] NOR_TT  = 4'b0001;
  localparam logic [3:0] AND_TT  = 4'b1000;
  localparam logic [3:0] OR_TT   = 4'b1110;
  localparam logic [3:0] NAND_TT = 4'b0111;
  localparam logic [3:0] XOR_TT  = 4'b0110;

  // FSM state encoding
  localparam logic [2:0] ENC_IDLE  = 3'd0;
  localparam logic [2:0] ENC_APPLY = 3'd1;
  localparam logic [2:0] ENC_WAIT  = 3'd2;
  localparam logic [2:0] ENC_CHECK = 3'd3;
  localparam logic [2:0] ENC_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ENC_IDLE,
    S_APPLY = ENC_APPLY,
    S_WAIT  = ENC_WAIT,
    S_CHECK = ENC_CHECK,
    S_DONE  = ENC_DONE
  } state_t;

endpackage

// File: rtl/gate_truth_checker_settle_timer.sv
// Settle countdown: loaded with SETTLE, counts down on tick, flags the last wait cycle.
// expire is combinational from the count; bypass is a constant for SETTLE==0.
// No flow control: tick is honoured every cycle it is high.
// Ports: clk, rst_n; load (reload counter), tick (decrement);
//        expire (count==1, i.e. final wait cycle), bypass (no wait needed).
module gate_truth_checker_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic tick,
  output logic expire,
  output logic bypass
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else if (load) begin
      cnt_q <= SETTLE[3:0];
    end else if (tick && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // The FSM leaves WAIT in the cycle the count shows 1, so WAIT lasts SETTLE cycles.
  assign expire = (cnt_q == 4'd1);
  assign bypass = (SETTLE == 0);

endmodule

// File: rtl/gate_truth_checker.sv
// Drives a 2-input gate through {A,B}=00..11, samples Y after a settle delay, checks a truth table.
// Latency: start accept to done high = 4*(SETTLE+2) cycles.
// No backpressure: start is ignored while busy; only reset aborts a run.
// Ports: clk, rst_n (async, active-low); start; A/B (registered stimulus); Y (gate output);
//        busy, done, pass; err_count (saturating); fail_vec (bit i = vector i mismatched).
module gate_truth_checker
  import gate_truth_checker_pkg::*;
#(
  parameter logic [3:0] EXPECTED = NOR_TT,
  parameter int         SETTLE   = 2,
  parameter int         ERR_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             A,
  output logic             B,
  input  logic             Y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  state_t             state_q, state_d;
  logic [1:0]         idx_q;
  logic               a_q, b_q;
  logic               busy_q, done_q;
  logic [ERR_W-1:0]   err_q;
  logic [3:0]         fail_q;
  logic               tmr_load, tmr_tick, tmr_expire, tmr_bypass;
  logic               mismatch;

  gate_truth_checker_settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .tick   (tmr_tick),
    .expire (tmr_expire),
    .bypass (tmr_bypass)
  );

  // Case-inequality so an X/Z on Y is reported as a mismatch in 4-state simulation.
  assign mismatch = (Y !== EXPECTED[idx_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_tick = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = S_APPLY;
      end
      S_APPLY: begin
        tmr_load = 1'b1;
        state_d  = tmr_bypass ? S_CHECK : S_WAIT;
      end
      S_WAIT: begin
        tmr_tick = 1'b1;
        if (tmr_expire) state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = (idx_q == 2'd3) ? S_DONE : S_APPLY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= 2'd0;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= '0;
      fail_q <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            idx_q  <= 2'd0;
            err_q  <= '0;
            fail_q <= 4'd0;
            done_q <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        S_APPLY: begin
          {a_q, b_q} <= idx_q;
        end
        S_CHECK: begin
          if (mismatch) begin
            fail_q[idx_q] <= 1'b1;
            if (!(&err_q)) err_q <= err_q + 1'b1;
          end
          if (idx_q == 2'd3) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = done_q && (err_q == '0);
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: two instances (SETTLE=2 and SETTLE=0), each wired to a
// behavioural gate whose truth table the stimulus picks per run (may contain X).
// The issuer derives expected events from the run rules; per-instance monitors pop and compare.
module tb_gate_truth_checker;
  import gate_truth_checker_pkg::*;

  localparam int         NDUT   = 2;
  localparam int         ERR_W  = 4;
  localparam logic [3:0] EXP_TT = NOR_TT;

  localparam int K_CLEAR = 0;
  localparam int K_AB    = 1;
  localparam int K_DONE  = 2;

  typedef struct {
    int               cyc;
    int               kind;
    logic [3:0]       fv;
    logic [ERR_W-1:0] ec;
    logic             ps;
    logic [1:0]       ab;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [NDUT-1:0] start;
  logic [NDUT-1:0] a, b, y, busy, done, pass;
  logic [ERR_W-1:0] err_count [NDUT];
  logic [3:0]       fail_vec  [NDUT];
  logic [3:0]       gate_tt   [NDUT];

  ev_t evq [NDUT][$];
  int  cyc = 0;
  int  n_vec = 0;
  int  n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int settle_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc=%0d: got %0h, expected %0h", nm, d, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    gate_truth_checker #(
      .EXPECTED (EXP_TT),
      .SETTLE   ((g == 0) ? 2 : 0),
      .ERR_W    (ERR_W)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start[g]),
      .A         (a[g]),
      .B         (b[g]),
      .Y         (y[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .pass      (pass[g]),
      .err_count (err_count[g]),
      .fail_vec  (fail_vec[g])
    );

    // Behavioural gate under test
    assign y[g] = gate_tt[g][{a[g], b[g]}];

    ev_t  e;
    logic done_prev = 1'b0;
    bit   seen_done;

    always @(negedge clk) begin
      seen_done = 1'b0;
      if (rst_n) begin
        while (evq[g].size() > 0 && evq[g][0].cyc == cyc) begin
          e = evq[g].pop_front();
          case (e.kind)
            K_CLEAR: chk("start_clear", g,
                         {busy[g], done[g], pass[g], err_count[g], fail_vec[g]},
                         {1'b1, 1'b0, 1'b0, {ERR_W{1'b0}}, 4'd0});
            K_AB: begin
              chk("ab_vector", g, {a[g], b[g]}, e.ab);
              chk("busy_in_run", g, busy[g], 1'b1);
            end
            default: begin
              seen_done = 1'b1;
              chk("done_high", g, done[g], 1'b1);
              chk("done_rise", g, done_prev, 1'b0);
              chk("busy_low", g, busy[g], 1'b0);
              chk("fail_vec", g, fail_vec[g], e.fv);
              chk("err_count", g, err_count[g], e.ec);
              chk("pass", g, pass[g], e.ps);
              chk("ab_hold", g, {a[g], b[g]}, 2'd3);
            end
          endcase
        end
        if (done[g] && !done_prev && !seen_done)
          chk("unexpected_done", g, done[g], 1'b0);
      end
      done_prev <= done[g];
    end
  end

  // Pushes the expected events of one run accepted at edge e0 and returns the done cycle.
  task automatic expect_run(input int d, input int e0, input logic [3:0] tt, output int done_cyc);
    int         s, l, errs, maxe;
    logic [3:0] fv;
    ev_t        ev;
    s = settle_of(d);
    l = s + 2;
    errs = 0;
    fv = 4'd0;
    maxe = (1 << ERR_W) - 1;
    for (int v = 0; v < VEC_COUNT; v++) begin
      if (tt[v] !== EXP_TT[v]) begin
        fv[v] = 1'b1;
        errs++;
      end
    end
    ev = '{cyc: e0, kind: K_CLEAR, fv: 4'd0, ec: '0, ps: 1'b0, ab: 2'd0};
    evq[d].push_back(ev);
    for (int k = 0; k < VEC_COUNT; k++) begin
      ev = '{cyc: e0 + k*l + s + 1, kind: K_AB, fv: 4'd0, ec: '0, ps: 1'b0, ab: 2'(k)};
      evq[d].push_back(ev);
    end
    done_cyc = e0 + VEC_COUNT*l;
    ev = '{cyc: done_cyc, kind: K_DONE, fv: fv,
           ec: ERR_W'((errs > maxe) ? maxe : errs), ps: (errs == 0), ab: 2'd3};
    evq[d].push_back(ev);
  endtask

  task automatic run(input int d, input logic [3:0] tt, input int gap, input int plen, input bit poke);
    int e0, done_cyc, l, off;
    gate_tt[d] = tt;
    repeat (gap) @(negedge clk);
    e0 = cyc + 1;
    l = settle_of(d) + 2;
    expect_run(d, e0, tt, done_cyc);
    start[d] = 1'b1;
    repeat (plen) @(negedge clk);
    start[d] = 1'b0;
    if (poke) begin
      // start while busy must be ignored; keep it clear of the DONE state
      off = $urandom_range(1, VEC_COUNT*l - plen - 2);
      repeat (off) @(negedge clk);
      start[d] = 1'b1;
      @(negedge clk);
      start[d] = 1'b0;
    end
    while (cyc < done_cyc + 1) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string nm);
    for (int d = 0; d < NDUT; d++)
      chk(nm, d, {a[d], b[d], busy[d], done[d], pass[d], err_count[d], fail_vec[d]}, 32'd0);
  endtask

  task automatic run_with_reset(input int d);
    int e0, done_cyc, l;
    gate_tt[d] = NOR_TT;
    @(negedge clk);
    e0 = cyc + 1;
    l = settle_of(d) + 2;
    expect_run(d, e0, NOR_TT, done_cyc);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    // first WAIT cycle of vector 2
    while (cyc < e0 + 2*l + 1) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    for (int k = 0; k < NDUT; k++) evq[k].delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] xt;
    rst_n = 1'b0;
    start = '0;
    for (int d = 0; d < NDUT; d++) gate_tt[d] = NOR_TT;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;

    run(0, NOR_TT, 2, 1, 1'b0);          // ideal NOR, SETTLE=2
    run(0, AND_TT, 1, 1, 1'b0);          // wrong gate, restarted from DONE
    run(1, NOR_TT, 2, 1, 1'b0);          // SETTLE=0 latency
    run_with_reset(0);
    run(0, NOR_TT, 2, 1, 1'b0);          // clean run after reset
    run(0, NOR_TT, 1, 2, 1'b1);          // start poked while busy
    run(0, XOR_TT, 1, 1, 1'b0);
    xt = NOR_TT;
    xt[1] = 1'bx;                        // unknown Y on vector 01
    run(0, xt, 1, 1, 1'b0);
    run(1, xt, 1, 1, 1'b0);

    for (int i = 0; i < 16; i++) begin
      run($urandom_range(0, 1), 4'($urandom), $urandom_range(1, 4),
          $urandom_range(1, 3), 1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk);
    for (int d = 0; d < NDUT; d++) chk("events_drained", d, evq[d].size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
